// File: rtl/mips_pkg.sv
// Shared MIPS encodings and constants for the multiply/divide unit.
package mips_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int MD_ITER = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
// Purely combinational; the caller guarantees rem_i < divisor_i unless the divisor is zero.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, divisor_i};
   // No borrow out of the top bit means the divisor fit.
   assign qbit_o  = ~diff[WIDTH];
   assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed 32-cycle latency, start ignored while busy.
// A single 64-bit work register holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             abort,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [4:0] LAST = 5'(MD_ITER - 1);

   md_state_e            state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic                 quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
   logic                 dz_q, dz_d, done_q, done_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d, raw_a_q, raw_a_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0]   w_q, w_d;

   logic                 is_mul, is_signed, run_mul, sa, sb, qbit;
   logic [WIDTH-1:0]     mag_a, mag_b, rem_nx;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next, div_next, prod;

   assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign sa        = is_signed & operand_a[WIDTH-1];
   assign sb        = is_signed & operand_b[WIDTH-1];
   assign mag_a     = sa ? -operand_a : operand_a;
   assign mag_b     = sb ? -operand_b : operand_b;
   assign run_mul   = (op_q == OP_MULT) || (op_q == OP_MULTU);

   assign mul_sum  = {1'b0, w_q[2*WIDTH-1:WIDTH]} + (w_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, w_q[WIDTH-1:1]};
   assign prod     = quo_neg_q ? -mul_next : mul_next;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (w_q[2*WIDTH-1:WIDTH]),
      .bit_i     (w_q[WIDTH-1]),
      .divisor_i (opnd_q),
      .rem_o     (rem_nx),
      .qbit_o    (qbit)
   );
   assign div_next = {rem_nx, w_q[WIDTH-2:0], qbit};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      opnd_d    = opnd_q;
      raw_a_d   = raw_a_q;
      w_d       = w_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (hi_we) hi_d = write_data;
            if (lo_we) lo_d = write_data;
            if (start && !abort) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               op_d      = op;
               quo_neg_d = sa ^ sb;
               rem_neg_d = sa;
               dz_d      = !is_mul && (operand_b == '0);
               raw_a_d   = operand_a;
               opnd_d    = is_mul ? mag_a : mag_b;
               w_d       = {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               w_d = run_mul ? mul_next : div_next;
               if (cnt_q == LAST) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  if (run_mul) begin
                     hi_d = prod[2*WIDTH-1:WIDTH];
                     lo_d = prod[WIDTH-1:0];
                  end else if (dz_q) begin
                     // Divide by zero reports the raw dividend with no sign fix-up.
                     hi_d = raw_a_q;
                     lo_d = '1;
                  end else begin
                     hi_d = rem_neg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
                     lo_d = quo_neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
                  end
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
         opnd_q    <= '0;
         raw_a_q   <= '0;
         w_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
         opnd_q    <= opnd_d;
         raw_a_q   <= raw_a_d;
         w_q       <= w_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q == ST_RUN);
   assign done = done_q;

endmodule
